// File: rtl/d_latch_if.sv
// Data/enable/status bundle for d_latch. The master drives D/En and observes Q and status;
// the slave is the latch itself.
interface d_latch_if #(
    parameter int unsigned WIDTH = 1
);
    logic [WIDTH-1:0] D;
    logic             En;
    logic [WIDTH-1:0] Q;
    logic             q_valid;
    logic             close_pulse;

    modport master (
        output D,
        output En,
        input  Q,
        input  q_valid,
        input  close_pulse
    );

    modport slave (
        input  D,
        input  En,
        output Q,
        output q_valid,
        output close_pulse
    );
endinterface

// File: rtl/d_latch.sv
// Level-sensitive D latch built from a clocked hold register: Q is transparent while En=1 and
// shows the last value captured on clk while En=0. Reports capture-valid and latch-close events.
module d_latch #(
    parameter int unsigned     WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic        clk,
    input logic        rst,
    d_latch_if.slave   bus
);

    logic [WIDTH-1:0] held_q;
    logic             en_q;
    logic             q_valid_q;
    logic             close_pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q        <= RESET_VALUE;
            en_q          <= 1'b0;
            q_valid_q     <= 1'b0;
            close_pulse_q <= 1'b0;
        end else begin
            if (bus.En) begin
                held_q    <= bus.D;
                q_valid_q <= 1'b1;
            end
            en_q          <= bus.En;
            close_pulse_q <= en_q & ~bus.En;
        end
    end

    // Reset overrides the transparent path so Q is RESET_VALUE even with En=1.
    always_comb begin
        bus.Q = held_q;
        if (rst) begin
            bus.Q = RESET_VALUE;
        end else if (bus.En) begin
            bus.Q = bus.D;
        end
    end

    assign bus.q_valid     = q_valid_q;
    assign bus.close_pulse = close_pulse_q;

endmodule

// File: tb/tb_d_latch.sv
// Scoreboard bench for d_latch: a 1-bit default instance and an 8-bit instance with a non-zero
// reset value. Expectations are queued as stimulus is applied and checked when outputs settle.
module tb_d_latch;

    logic clk  = 1'b0;
    logic rst1 = 1'b0;
    logic rst8 = 1'b0;

    always #5 clk = ~clk;

    d_latch_if #(.WIDTH(1)) b1 ();
    d_latch_if #(.WIDTH(8)) b8 ();

    d_latch #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1)
    );

    d_latch #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (b8)
    );

    typedef struct {
        string      tag;
        bit         sel8;
        logic [7:0] q;
        logic       v;
        logic       c;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input bit sel8, input logic [7:0] q,
                              input logic v, input logic c);
        exp_t e;
        e.tag  = tag;
        e.sel8 = sel8;
        e.q    = q;
        e.v    = v;
        e.c    = c;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel8) begin
                check({e.tag, ".q"}, b8.Q, e.q);
                check({e.tag, ".v"}, {7'b0, b8.q_valid}, {7'b0, e.v});
                check({e.tag, ".c"}, {7'b0, b8.close_pulse}, {7'b0, e.c});
            end else begin
                check({e.tag, ".q"}, {7'b0, b1.Q}, e.q);
                check({e.tag, ".v"}, {7'b0, b1.q_valid}, {7'b0, e.v});
                check({e.tag, ".c"}, {7'b0, b1.close_pulse}, {7'b0, e.c});
            end
        end
    endtask

    // Combinational check between edges.
    task automatic settle();
        #1;
        drain();
    endtask

    // Check just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        b1.D = 1'b0;  b1.En = 1'b0;
        b8.D = 8'h00; b8.En = 1'b0;
        #1;
        rst1 = 1'b1;
        rst8 = 1'b1;
        expect_out("rst1", 0, 8'h00, 0, 0);
        expect_out("rst8", 1, 8'hA5, 0, 0);
        settle();
        tick();
        rst1 = 1'b0;
        expect_out("rel1", 0, 8'h00, 0, 0);
        settle();

        // En low: D ignored, nothing captured.
        for (int i = 0; i < 3; i++) begin
            b1.D = ~b1.D;
            expect_out("hold_lo", 0, 8'h00, 0, 0);
            tick();
        end

        // Transparent: D=0, first capture, then D=1 before the next edge.
        b1.En = 1'b1; b1.D = 1'b0;
        expect_out("open_pre", 0, 8'h00, 0, 0);
        settle();
        expect_out("open_cap", 0, 8'h00, 1, 0);
        tick();
        b1.D = 1'b1;
        expect_out("open_d1", 0, 8'h01, 1, 0);
        settle();
        expect_out("open_cap1", 0, 8'h01, 1, 0);
        tick();

        // Close with held=1, then D toggles.
        b1.En = 1'b0;
        expect_out("close_pre", 0, 8'h01, 1, 0);
        settle();
        expect_out("close_pulse", 0, 8'h01, 1, 1);
        tick();
        b1.D = 1'b0;
        expect_out("close_d0", 0, 8'h01, 1, 1);
        settle();
        expect_out("close_end", 0, 8'h01, 1, 0);
        tick();
        b1.D = 1'b1;
        expect_out("close_t1", 0, 8'h01, 1, 0);
        tick();
        b1.D = 1'b0;
        expect_out("close_t0", 0, 8'h01, 1, 0);
        tick();

        // Reopen and follow D 1,0,1 with no pulse.
        b1.En = 1'b1; b1.D = 1'b1;
        expect_out("follow1", 0, 8'h01, 1, 0);
        settle();
        b1.D = 1'b0;
        expect_out("follow0", 0, 8'h00, 1, 0);
        settle();
        expect_out("follow_e0", 0, 8'h00, 1, 0);
        tick();
        b1.D = 1'b1;
        expect_out("follow1b", 0, 8'h01, 1, 0);
        settle();
        expect_out("follow_e1", 0, 8'h01, 1, 0);
        tick();

        // En falls together with a D change: Q keeps the sampled value.
        b1.En = 1'b0; b1.D = 1'b0;
        expect_out("simul", 0, 8'h01, 1, 0);
        settle();
        expect_out("simul_pulse", 0, 8'h01, 1, 1);
        tick();

        // Reset while transparent, then release with En=1.
        b1.En = 1'b1; b1.D = 1'b1;
        expect_out("mid_open", 0, 8'h01, 1, 1);
        settle();
        tick();
        rst1 = 1'b1;
        expect_out("mid_rst", 0, 8'h00, 0, 0);
        settle();
        expect_out("mid_rst_clk", 0, 8'h00, 0, 0);
        tick();
        rst1 = 1'b0;
        expect_out("mid_rel", 0, 8'h01, 0, 0);
        settle();
        expect_out("mid_recap", 0, 8'h01, 1, 0);
        tick();

        // 8-bit instance with reset value A5.
        expect_out("w8_rst", 1, 8'hA5, 0, 0);
        settle();
        rst8 = 1'b0;
        b8.En = 1'b1; b8.D = 8'h3C;
        expect_out("w8_open", 1, 8'h3C, 0, 0);
        settle();
        expect_out("w8_cap", 1, 8'h3C, 1, 0);
        tick();
        b8.En = 1'b0; b8.D = 8'hFF;
        expect_out("w8_hold", 1, 8'h3C, 1, 0);
        settle();
        expect_out("w8_pulse", 1, 8'h3C, 1, 1);
        tick();
        expect_out("w8_end", 1, 8'h3C, 1, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
